usb_rx_pkt_decoder: RTL and testbench

- Parametrised serial receive-side packet decoder for the USB device datapath.
- Sits between the bit unstuffer and the protocol FSM.
- Captures and validates the PID, then accepts either a handshake packet or a variable-length DATA0/DATA1 packet of 0..MAX_BYTES bytes.
- Checks CRC16 by residual, so the payload length does not need to be known in advance. Reports status, PID, payload, byte count and error class to the protocol FSM.

---
 rtl/usb_rx_pkt_decoder.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_pkt_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_decoder.sv
// Serial PID/handshake/DATAx decoder with residual CRC16 check; RX_STALL_PID_EN makes STALL a handshake.
// Status/error registered on the end_pkt (or 8th PID bit) edge; no backpressure, bit_valid gaps stall decoding.
module usb_rx_pkt_decoder #(
    parameter int MAX_BYTES = 8,
    parameter int CNT_W     = $clog2(MAX_BYTES*8+17),
    parameter int BC_W      = $clog2(MAX_BYTES+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   s_in,
    input  logic                   bit_valid,
    input  logic                   start_pkt,
    input  logic                   end_pkt,
    input  logic                   pkt_ack,
    output logic                   pkt_status,
    output logic [7:0]             rc_pid,
    output logic [MAX_BYTES*8-1:0] rc_data,
    output logic [BC_W-1:0]        byte_cnt,
    output logic                   crc_error,
    output logic                   pid_error,
    output logic                   len_error,
    output logic                   busy
);
    localparam int               WIN_W    = MAX_BYTES*8 + 16;
    localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(WIN_W);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      CRC_RES  = 16'h800D;

    typedef enum logic [2:0] {S_IDLE, S_PID, S_HS_EOP, S_DATA, S_DONE, S_ERROR} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_inc, cnt_end;
    logic [15:0]      crc, crc_bit, crc_end;
    logic [WIN_W-1:0] win;
    logic [7:0]       pid_nxt;
    logic             pid_hs, pid_data, pid_last;
    logic             set_status, set_crc, set_pid, set_len;

    assign pid_nxt  = {rc_pid[6:0], s_in};
    assign pid_last = bit_valid && (cnt == CNT_W'(7));
    assign pid_data = (pid_nxt == 8'hC3) || (pid_nxt == 8'hD2);
`ifdef RX_STALL_PID_EN
    assign pid_hs   = (pid_nxt == 8'h4B) || (pid_nxt == 8'h5A) || (pid_nxt == 8'h78);
`else
    assign pid_hs   = (pid_nxt == 8'h4B) || (pid_nxt == 8'h5A);
`endif

    assign cnt_inc = cnt + CNT_W'(1);
    assign crc_bit = {crc[14:0], 1'b0} ^ ((crc[15] ^ s_in) ? 16'h8005 : 16'h0000);
    // The bit arriving with end_pkt must be folded in before the final checks.
    assign cnt_end = bit_valid ? cnt_inc : cnt;
    assign crc_end = bit_valid ? crc_bit : crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        set_status = 1'b0;
        set_crc    = 1'b0;
        set_pid    = 1'b0;
        set_len    = 1'b0;
        busy       = (state != S_IDLE);
        if (!abort) begin
            case (state)
                S_PID: begin
                    if (pid_last) begin
                        if (!(pid_hs || pid_data)) set_pid = 1'b1;
                        else if (end_pkt) begin
                            if (pid_hs) set_status = 1'b1;
                            else        set_len    = 1'b1;
                        end
                    end else if (end_pkt) begin
                        set_len = 1'b1;
                    end
                end
                S_HS_EOP: begin
                    if (bit_valid)    set_len    = 1'b1;
                    else if (end_pkt) set_status = 1'b1;
                end
                S_DATA: begin
                    if (bit_valid && cnt == MAX_BITS) set_len = 1'b1;
                    else if (end_pkt) begin
                        if (cnt_end < CNT_W'(16) || cnt_end[2:0] != 3'd0) set_len = 1'b1;
                        else if (crc_end != CRC_RES)                       set_crc = 1'b1;
                        else                                               set_status = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start_pkt && bit_valid) state_nxt = S_PID;
                S_PID: begin
                    if (set_pid || set_len)  state_nxt = S_ERROR;
                    else if (set_status)     state_nxt = S_DONE;
                    else if (pid_last)       state_nxt = pid_hs ? S_HS_EOP : S_DATA;
                end
                S_HS_EOP, S_DATA: begin
                    if (set_len || set_crc)  state_nxt = S_ERROR;
                    else if (set_status)     state_nxt = S_DONE;
                end
                S_DONE, S_ERROR: if (pkt_ack) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            crc        <= CRC_INIT;
            win        <= '0;
            rc_pid     <= '0;
            rc_data    <= '0;
            byte_cnt   <= '0;
            pkt_status <= 1'b0;
            crc_error  <= 1'b0;
            pid_error  <= 1'b0;
            len_error  <= 1'b0;
        end else if (abort) begin
            cnt        <= '0;
            crc        <= CRC_INIT;
            pkt_status <= 1'b0;
            crc_error  <= 1'b0;
            pid_error  <= 1'b0;
            len_error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_pkt && bit_valid) begin
                    rc_pid <= pid_nxt;
                    cnt    <= CNT_W'(1);
                end
                S_PID: if (bit_valid) begin
                    rc_pid <= pid_nxt;
                    cnt    <= cnt_inc;
                    if (state_nxt == S_DATA) begin
                        cnt <= '0;
                        crc <= CRC_INIT;
                        win <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_valid && cnt != MAX_BITS) begin
                        win <= {win[WIN_W-2:0], s_in};
                        cnt <= cnt_inc;
                        crc <= crc_bit;
                    end
                    // Window was cleared on entry, so unused upper payload bits read as 0.
                    if (set_status) begin
                        rc_data  <= bit_valid ? win[WIN_W-2:15] : win[WIN_W-1:16];
                        byte_cnt <= BC_W'((cnt_end - CNT_W'(16)) >> 3);
                    end
                end
                S_DONE, S_ERROR: if (pkt_ack) begin
                    cnt        <= '0;
                    crc        <= CRC_INIT;
                    pkt_status <= 1'b0;
                    crc_error  <= 1'b0;
                    pid_error  <= 1'b0;
                    len_error  <= 1'b0;
                end
                default: ;
            endcase
            if (set_status) pkt_status <= 1'b1;
            if (set_crc)    crc_error  <= 1'b1;
            if (set_pid)    pid_error  <= 1'b1;
            if (set_len)    len_error  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Randomised directed bench for usb_rx_pkt_decoder against a packet-level reference model.
module tb_usb_rx_pkt_decoder;
    localparam int MB   = 8;
    localparam int DW   = MB*8;
    localparam int BC_W = $clog2(MB+1);

    typedef bit bitq_t[$];
    typedef struct packed {
        logic [3:0]      flags;   // {status, crc, pid, len}
        logic [BC_W-1:0] bc;
        logic [DW-1:0]   data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, abort, s_in, bit_valid, start_pkt, end_pkt, pkt_ack;
    logic            pkt_status, crc_error, pid_error, len_error, busy;
    logic [7:0]      rc_pid;
    logic [DW-1:0]   rc_data;
    logic [BC_W-1:0] byte_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t last;

    usb_rx_pkt_decoder #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .s_in(s_in), .bit_valid(bit_valid),
        .start_pkt(start_pkt), .end_pkt(end_pkt), .pkt_ack(pkt_ack),
        .pkt_status(pkt_status), .rc_pid(rc_pid), .rc_data(rc_data), .byte_cnt(byte_cnt),
        .crc_error(crc_error), .pid_error(pid_error), .len_error(len_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bitq_t b);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h8005 : 16'h0000);
        return c;
    endfunction

    // nbytes < 0 builds a bare PID (handshake or bad PID).
    function automatic bitq_t build(input logic [7:0] pid, input int nbytes, input int flip_at, input int extra);
        bitq_t q, pl;
        logic [15:0] c;
        for (int i = 7; i >= 0; i--) q.push_back(pid[i]);
        if (nbytes >= 0) begin
            for (int i = 0; i < nbytes*8; i++) pl.push_back(1'($urandom_range(0, 1)));
            c = ~crc_of(pl);
            if (flip_at >= 0 && flip_at < pl.size()) pl[flip_at] = !pl[flip_at];
            q = {q, pl};
            for (int i = 15; i >= 0; i--) q.push_back(c[i]);
        end
        for (int i = 0; i < extra; i++) q.push_back(1'($urandom_range(0, 1)));
        return q;
    endfunction

    function automatic bit is_hs(input logic [7:0] p);
`ifdef RX_STALL_PID_EN
        return (p == 8'h4B) || (p == 8'h5A) || (p == 8'h78);
`else
        return (p == 8'h4B) || (p == 8'h5A);
`endif
    endfunction

    function automatic exp_t model(input bitq_t q, input exp_t prev);
        exp_t        e = prev;
        logic [7:0]  pid = 8'h00;
        int          len;
        bitq_t       body;
        e.flags = 4'b0000;
        for (int i = 0; i < 8; i++) pid = {pid[6:0], q[i]};
        len = q.size() - 8;
        if (is_hs(pid)) begin
            e.flags = (len == 0) ? 4'b1000 : 4'b0001;
        end else if (pid == 8'hC3 || pid == 8'hD2) begin
            if (len > DW + 16 || len < 16 || len % 8 != 0) e.flags = 4'b0001;
            else begin
                body = q[8:$];
                if (crc_of(body) != 16'h800D) e.flags = 4'b0100;
                else begin
                    e.flags = 4'b1000;
                    e.bc    = BC_W'((len - 16) / 8);
                    e.data  = '0;
                    for (int i = 0; i < len - 16; i++) e.data = {e.data[DW-2:0], body[i]};
                end
            end
        end else begin
            e.flags = 4'b0010;
        end
        return e;
    endfunction

    task automatic idle_inputs;
        bit_valid = 1'b0; start_pkt = 1'b0; end_pkt = 1'b0; s_in = 1'b0;
    endtask

    // end_mode: 0 = separate EOP cycle, 1 = EOP with last bit, 2 = no EOP
    task automatic send(input bitq_t q, input int end_mode, input bit stall);
        for (int i = 0; i < q.size(); i++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; idle_inputs(); end
            end
            @(posedge clk); #1;
            bit_valid = 1'b1; s_in = q[i]; start_pkt = (i == 0);
            end_pkt   = (end_mode == 1) && (i == q.size() - 1);
        end
        if (end_mode == 0) begin
            @(posedge clk); #1; idle_inputs(); end_pkt = 1'b1;
        end
        @(posedge clk); #1; idle_inputs();
    endtask

    task automatic do_ack(input string tag);
        @(posedge clk); #1; pkt_ack = 1'b1;
        @(posedge clk); #1; pkt_ack = 1'b0;
        chk({tag, "_ack_busy"}, busy, 1'b0);
        chk({tag, "_ack_flags"}, {pkt_status, crc_error, pid_error, len_error}, 4'b0000);
    endtask

    task automatic run_pkt(input string tag, input bitq_t q, input bit data_pkt, input bit stall);
        exp_t e;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) p = {p[6:0], q[i]};
        e = model(q, last);
        send(q, (data_pkt && $urandom_range(0, 1) == 1) ? 1 : 0, stall);
        chk({tag, "_flags"}, {pkt_status, crc_error, pid_error, len_error}, e.flags);
        chk({tag, "_pid"}, rc_pid, p);
        chk({tag, "_bcnt"}, byte_cnt, e.bc);
        chk({tag, "_data"}, rc_data, e.data);
        last = e;
        do_ack(tag);
    endtask

    initial begin
        bitq_t      q;
        logic [7:0] rp;
        int         nb;
        last = '0;
        rst_n = 1'b0; abort = 1'b0; pkt_ack = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {pkt_status, crc_error, pid_error, len_error}, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pid", rc_pid, 8'h00);
        chk("rst_data", rc_data, 64'h0);
        chk("rst_bcnt", byte_cnt, 4'h0);
        rst_n = 1'b1;

        run_pkt("ack", build(8'h4B, -1, -1, 0), 1'b0, 1'b0);
        run_pkt("nak", build(8'h5A, -1, -1, 0), 1'b0, 1'b1);
        run_pkt("zlp", build(8'hC3, 0, -1, 0), 1'b1, 1'b0);
        run_pkt("full", build(8'hD2, MB, -1, 0), 1'b1, 1'b1);
        run_pkt("flip", build(8'hD2, MB, $urandom_range(0, MB*8-1), 0), 1'b1, 1'b1);
        run_pkt("badpid", build(8'h4C, -1, -1, 0), 1'b0, 1'b0);
        run_pkt("extra3", build(8'hC3, $urandom_range(0, MB-1), -1, 3), 1'b1, 1'b1);
        run_pkt("ovf", build(8'hC3, MB+1, -1, 0), 1'b1, 1'b0);
        run_pkt("ackx", build(8'h4B, -1, -1, 1), 1'b0, 1'b0);
        run_pkt("stall", build(8'h78, -1, -1, 0), 1'b0, 1'b0);

        // A completed packet must ignore a following packet until acknowledged.
        q = build(8'h5A, -1, -1, 0);
        send(q, 0, 1'b0);
        send(build(8'hC3, 2, -1, 0), 0, 1'b0);
        chk("hold_flags", {pkt_status, crc_error, pid_error, len_error}, 4'b1000);
        chk("hold_pid", rc_pid, 8'h5A);
        do_ack("hold");

        // Abort mid-DATA, then a fresh packet still decodes.
        q = build(8'hC3, 4, -1, 0);
        send(q[0:29], 2, 1'b0);
        chk("abrt_busy_pre", busy, 1'b1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abrt_busy", busy, 1'b0);
        chk("abrt_flags", {pkt_status, crc_error, pid_error, len_error}, 4'b0000);
        chk("abrt_pid", rc_pid, 8'hC3);
        run_pkt("post_abrt", build(8'hD2, 3, -1, 0), 1'b1, 1'b1);

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 5))
                0:       rp = 8'h4B;
                1:       rp = 8'h5A;
                2:       rp = 8'h78;
                3:       rp = 8'hC3;
                4:       rp = 8'hD2;
                default: rp = 8'($urandom_range(0, 255));
            endcase
            if (rp == 8'hC3 || rp == 8'hD2) begin
                nb = $urandom_range(0, MB);
                q  = build(rp, nb, ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb*8) : -1,
                           ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : 0);
                run_pkt($sformatf("rnd%0d", k), q, 1'b1, 1'b1);
            end else begin
                q = build(rp, -1, -1, ($urandom_range(0, 4) == 0) ? 1 : 0);
                run_pkt($sformatf("rnd%0d", k), q, 1'b0, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
